// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file, 64-bit counters, prescaled timer and trap prioritiser.
// CSR reads and trap outputs are combinational; all state commits on the clk posedge.
module machine_csr_unit #(
  parameter int          NUM_IRQ     = 4,
  parameter int          PRESCALE    = 10,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] NMI_VECTOR  = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic               instr_retire,
  input  logic [31:0]        pc,
  input  logic               nmi,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mret,
  output logic               trap_req,
  output logic [31:0]        trap_cause,
  output logic [31:0]        trap_vector,
  input  logic               trap_ack
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MTIME     = 12'hB01;
  localparam logic [11:0] A_MTIMEH    = 12'hB81;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MTIMECMP  = 12'hB03;
  localparam logic [11:0] A_MTIMECMPH = 12'hB83;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {RUN, HANDLER} state_t;

  state_t        state_q, state_d;
  logic          mstatus_mie_q, mstatus_mie_d;
  logic          mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]   mie_q, mie_d;
  logic [31:0]   mtvec_q, mtvec_d;
  logic [31:0]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic [63:0]   mcycle_q, mcycle_d;
  logic [63:0]   minstret_q, minstret_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          nmi_prev_q, nmi_prev_d;
  logic          nmi_pend_q, nmi_pend_d;
  logic          ecall_pend_q, ecall_pend_d;
  logic          ebreak_pend_q, ebreak_pend_d;

  logic          mtip;
  logic          tick;
  logic [31:0]   mip;
  logic [31:0]   mie_mask;
  logic          wr;
  logic [31:0]   wval;
  logic [NUM_IRQ-1:0] irq_en;
  logic          irq_any;
  logic [4:0]    irq_idx;
  logic          timer_en;
  logic          sel_nmi, sel_ebreak, sel_ecall, sel_int;
  logic          take;

  // A write to one half replaces that half; the other half sees the increment minus any carry.
  function automatic logic [63:0] cnt_next(input logic [63:0] q, input logic inc,
                                           input logic wr_lo, input logic wr_hi,
                                           input logic [31:0] wv);
    logic [63:0] n;
    n = inc ? q + 64'd1 : q;
    if (wr_lo) n = {q[63:32], wv};
    if (wr_hi) n = {wv, n[31:0]};
    return n;
  endfunction

  assign mtip = (mtime_q >= mtimecmp_q);
  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    mip      = '0;
    mie_mask = '0;
    mip[7]       = mtip;
    mip[11]      = |irq;
    mie_mask[7]  = 1'b1;
    mie_mask[11] = 1'b1;
    for (int k = 0; k < NUM_IRQ; k++) begin
      mip[16+k]      = irq[k];
      mie_mask[16+k] = 1'b1;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS:   csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:       csr_rdata = mie_q;
      A_MTVEC:     csr_rdata = mtvec_q;
      A_MEPC:      csr_rdata = mepc_q;
      A_MCAUSE:    csr_rdata = mcause_q;
      A_MIP:       csr_rdata = mip;
      A_MCYCLE:    csr_rdata = mcycle_q[31:0];
      A_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      A_MTIME:     csr_rdata = mtime_q[31:0];
      A_MTIMEH:    csr_rdata = mtime_q[63:32];
      A_MINSTRET:  csr_rdata = minstret_q[31:0];
      A_MINSTRETH: csr_rdata = minstret_q[63:32];
      A_MTIMECMP:  csr_rdata = mtimecmp_q[31:0];
      A_MTIMECMPH: csr_rdata = mtimecmp_q[63:32];
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    wr = (csr_op != 2'b00);
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = csr_rdata | csr_wdata;
      2'b11:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Trap prioritisation: nmi > ebreak > ecall > timer > lowest-numbered irq.
  always_comb begin
    irq_en   = irq & mie_q[16 +: NUM_IRQ] & {NUM_IRQ{mstatus_mie_q}};
    irq_any  = |irq_en;
    irq_idx  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_en[k]) irq_idx = 5'(k);
    end
    timer_en   = mtip & mie_q[7] & mstatus_mie_q;
    sel_nmi    = nmi_pend_q;
    sel_ebreak = !sel_nmi && ebreak_pend_q;
    sel_ecall  = !sel_nmi && !ebreak_pend_q && ecall_pend_q;
    sel_int    = !sel_nmi && !ebreak_pend_q && !ecall_pend_q && (timer_en || irq_any);

    trap_req   = sel_nmi || ebreak_pend_q || ecall_pend_q || timer_en || irq_any;
    trap_cause = '0;
    if (sel_nmi)         trap_cause = 32'h8000_0000;
    else if (sel_ebreak) trap_cause = 32'd3;
    else if (sel_ecall)  trap_cause = 32'd11;
    else if (timer_en)   trap_cause = 32'h8000_0007;
    else if (irq_any)    trap_cause = 32'h8000_0010 + {27'd0, irq_idx};

    if (sel_nmi)
      trap_vector = NMI_VECTOR;
    else if (sel_int && mtvec_q[0])
      trap_vector = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
    else
      trap_vector = {mtvec_q[31:2], 2'b00};
  end

  assign take = trap_ack && trap_req;

  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtimecmp_d     = mtimecmp_q;
    nmi_prev_d     = nmi;
    nmi_pend_d     = nmi_pend_q | (nmi & ~nmi_prev_q);
    ecall_pend_d   = ecall_pend_q | ecall;
    ebreak_pend_d  = ebreak_pend_q | ebreak;
    presc_d        = tick ? '0 : presc_q + PW'(1);

    if (wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:       mie_d = wval & mie_mask;
        A_MTVEC:     mtvec_d = wval;
        A_MEPC:      mepc_d = {wval[31:1], 1'b0};
        A_MCAUSE:    mcause_d = wval;
        A_MTIMECMP:  mtimecmp_d[31:0] = wval;
        A_MTIMECMPH: mtimecmp_d[63:32] = wval;
        default: ;
      endcase
    end

    mcycle_d   = cnt_next(mcycle_q, 1'b1,
                          wr && csr_addr == A_MCYCLE, wr && csr_addr == A_MCYCLEH, wval);
    minstret_d = cnt_next(minstret_q, instr_retire,
                          wr && csr_addr == A_MINSTRET, wr && csr_addr == A_MINSTRETH, wval);
    mtime_d    = cnt_next(mtime_q, tick,
                          wr && csr_addr == A_MTIME, wr && csr_addr == A_MTIMEH, wval);

    if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      state_d        = RUN;
    end

    // Taking a trap overrides both mret and any same-cycle CSR write.
    if (take) begin
      mepc_d         = {pc[31:1], 1'b0};
      mcause_d       = trap_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      state_d        = HANDLER;
      if (sel_nmi)    nmi_pend_d    = nmi & ~nmi_prev_q;
      if (sel_ebreak) ebreak_pend_d = ebreak;
      if (sel_ecall)  ecall_pend_d  = ecall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      mtime_q        <= '0;
      mtimecmp_q     <= '0;
      presc_q        <= '0;
      nmi_prev_q     <= 1'b0;
      nmi_pend_q     <= 1'b0;
      ecall_pend_q   <= 1'b0;
      ebreak_pend_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
      presc_q        <= presc_d;
      nmi_prev_q     <= nmi_prev_d;
      nmi_pend_q     <= nmi_pend_d;
      ecall_pend_q   <= ecall_pend_d;
      ebreak_pend_q  <= ebreak_pend_d;
    end
  end

endmodule

// File: tb/tb_machine_csr_unit.sv
// Directed bench for machine_csr_unit: reset, counters, timer/irq/exception/nmi traps, CSR corner cases.
module tb_machine_csr_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        instr_retire;
  logic [31:0] pc;
  logic        nmi, ecall, ebreak, mret, trap_ack;
  logic [3:0]  irq;
  logic        trap_req;
  logic [31:0] trap_cause, trap_vector;

  int checks = 0;
  int errors = 0;

  machine_csr_unit dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .instr_retire(instr_retire), .pc(pc), .nmi(nmi), .ecall(ecall),
    .ebreak(ebreak), .irq(irq), .mret(mret), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_vector(trap_vector), .trap_ack(trap_ack)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, {32'd0, csr_rdata}, {32'd0, exp});
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = d;
    @(negedge clk);
    csr_op    = 2'b00;
    csr_wdata = '0;
  endtask

  task automatic pulse_ack(input logic [31:0] p);
    pc = p;
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    csr_addr = '0; csr_op = '0; csr_wdata = '0; instr_retire = 1'b0; pc = '0;
    nmi = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; trap_ack = 1'b0; irq = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] ra [14];
    logic [31:0] rv [14];
    ra = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00,
           12'hB80, 12'hB01, 12'hB81, 12'hB02, 12'hB82, 12'hB03, 12'hB83};
    rv = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h80, 32'h0,
           32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset values: mip shows MTIP because mtime(0) >= mtimecmp(0).
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) rdchk($sformatf("rst_csr_%h", ra[i]), ra[i], rv[i]);
    chk("rst_trap_req", {63'd0, trap_req}, 64'd0);
    chk("rst_trap_cause", {32'd0, trap_cause}, 64'd0);
    chk("rst_trap_vector", {32'd0, trap_vector}, 64'h100);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    rdchk("mcycle_25", 12'hB00, 32'd25);
    rdchk("mtime_25", 12'hB01, 32'd2);
    rdchk("minstret_25", 12'hB02, 32'd0);

    // Timer interrupt at mtime == mtimecmp.
    do_reset();
    wr(12'hB03, 2'b01, 32'd5);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h300, 2'b10, 32'h8);
    chk("tmr_not_yet", {63'd0, trap_req}, 64'd0);
    begin : wait_tmr
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge clk);
        hit = trap_req;
      end
      chk("tmr_seen", {63'd0, hit}, 64'd1);
    end
    rdchk("tmr_mtime", 12'hB01, 32'd5);
    chk("tmr_cause", {32'd0, trap_cause}, 64'h8000_0007);
    chk("tmr_vector", {32'd0, trap_vector}, 64'h100);
    pulse_ack(32'h40);
    rdchk("tmr_mepc", 12'h341, 32'h40);
    rdchk("tmr_mstatus_ack", 12'h300, 32'h80);
    rdchk("tmr_mcause", 12'h342, 32'h8000_0007);
    chk("tmr_masked", {63'd0, trap_req}, 64'd0);
    pulse_mret();
    rdchk("tmr_mstatus_mret", 12'h300, 32'h88);
    chk("tmr_req_again", {63'd0, trap_req}, 64'd1);

    // ecall and irq[2] together, vectored mtvec.
    do_reset();
    wr(12'h305, 2'b01, 32'h101);
    wr(12'h304, 2'b01, 32'h0004_0000);
    wr(12'h300, 2'b10, 32'h8);
    ecall = 1'b1;
    irq   = 4'b0100;
    #1;
    chk("irq_same_cycle_cause", {32'd0, trap_cause}, 64'h8000_0012);
    @(negedge clk);
    ecall = 1'b0;
    chk("ecall_cause", {32'd0, trap_cause}, 64'd11);
    chk("ecall_vector", {32'd0, trap_vector}, 64'h100);
    pulse_ack(32'h24);
    rdchk("ecall_mcause", 12'h342, 32'd11);
    rdchk("ecall_mepc", 12'h341, 32'h24);
    chk("ecall_req_cleared", {63'd0, trap_req}, 64'd0);
    pulse_mret();
    chk("irq_req", {63'd0, trap_req}, 64'd1);
    chk("irq_cause", {32'd0, trap_cause}, 64'h8000_0012);
    chk("irq_vector", {32'd0, trap_vector}, 64'h148);
    pulse_ack(32'h30);
    ebreak = 1'b1;
    @(negedge clk);
    ebreak = 1'b0;
    chk("ebreak_cause", {32'd0, trap_cause}, 64'd3);
    chk("ebreak_vector", {32'd0, trap_vector}, 64'h100);

    // Reset in handler with ebreak still pending drops everything.
    do_reset();
    chk("rst_clears_pend", {63'd0, trap_req}, 64'd0);
    rdchk("rst_mstatus", 12'h300, 32'h0);

    // NMI with MIE=0; same-cycle mstatus write loses to the ack.
    nmi = 1'b1;
    #1;
    chk("nmi_not_yet", {63'd0, trap_req}, 64'd0);
    @(negedge clk);
    nmi = 1'b0;
    chk("nmi_req", {63'd0, trap_req}, 64'd1);
    chk("nmi_vector", {32'd0, trap_vector}, 64'h80);
    chk("nmi_cause", {32'd0, trap_cause}, 64'h8000_0000);
    csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h88;
    pulse_ack(32'h11);
    csr_op = 2'b00; csr_wdata = '0;
    rdchk("nmi_mstatus_ack_wins", 12'h300, 32'h0);
    rdchk("nmi_mepc", 12'h341, 32'h10);
    chk("nmi_req_cleared", {63'd0, trap_req}, 64'd0);

    // mcycle low-half wrap and high-half write on the wrap cycle.
    do_reset();
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rdchk("cyc_lo_ff", 12'hB00, 32'hFFFF_FFFF);
    rdchk("cyc_hi_0", 12'hB80, 32'd0);
    @(negedge clk);
    rdchk("cyc_lo_wrap", 12'hB00, 32'd0);
    rdchk("cyc_hi_1", 12'hB80, 32'd1);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b01, 32'd7);
    rdchk("cyc_hi_write_wins", 12'hB80, 32'd7);
    rdchk("cyc_lo_wrap2", 12'hB00, 32'd0);

    // Read-only, unmapped and no-op writes.
    do_reset();
    rdchk("mip_before", 12'h344, 32'h80);
    wr(12'h344, 2'b11, 32'hFFFF_FFFF);
    rdchk("mip_after", 12'h344, 32'h80);
    wr(12'h7C0, 2'b01, 32'hDEAD_BEEF);
    rdchk("unmapped", 12'h7C0, 32'd0);
    wr(12'h305, 2'b10, 32'd0);
    rdchk("mtvec_set0", 12'h305, 32'h100);
    wr(12'h341, 2'b01, 32'h123);
    rdchk("mepc_bit0", 12'h341, 32'h122);
    wr(12'h304, 2'b01, 32'h0001_0880);
    wr(12'h304, 2'b11, 32'h80);
    rdchk("mie_clear", 12'h304, 32'h0001_0800);
    instr_retire = 1'b1;
    repeat (3) @(negedge clk);
    instr_retire = 1'b0;
    rdchk("minstret_3", 12'hB02, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
